bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter producing the packed 5-digit BCD word consumed by the board's 7-segment display driver. It takes a 16-bit unsigned value from the processor's display/debug path on a start pulse. It converts with the shift-and-add-3 (double-dabble) algorithm, one bit per clock, and holds the result stable until the next conversion completes. Optional leading-zero blanking emits nibble 4'hF, which the display driver renders as a dark digit.

## Interface

Parameters:
- `WIDTH`, 16, binary input width.
- `DIGITS`, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1.

Ports:
- `clk`  input  1  single system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  conversion request; sampled only while idle.
- `bin`  input  WIDTH  unsigned value; captured on the edge that accepts `start`.
- `lz_blank`  input  1  leading-zero blanking enable; captured together with `bin`.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  single-cycle pulse, high in the cycle `bcd` first shows the new result.
- `bcd`  output  4*DIGITS  packed result; digit 0 (units) in [3:0], digit k in [4k+3:4k].

## Operation

- State machine: IDLE, SHIFT.
  - IDLE: `busy`=0. On an edge with `start`=1:
    - load the shift register with {DIGITS*4 zeros, `bin`};
    - latch `lz_blank`;
    - clear the bit counter;
    - go to SHIFT.
  - SHIFT: `busy`=1. Each edge does two steps on the current register:
    - add 3 to every BCD nibble that is ≥ 5;
    - shift the whole register left by 1 and increment the counter.
  - On the edge performing the WIDTH-th shift: compute the final BCD field, apply blanking, load it into `bcd`, set `done`=1, go to IDLE.
- `done` is cleared on every edge where it is not being set. It is never high for two consecutive cycles.
- Blanking, when enabled:
  - Scan from digit DIGITS−1 down to digit 1; each digit that is 0 and has only zero digits above it becomes 4'hF.
  - Digit 0 is never blanked, so 0 displays as a single "0".
  - When blanking is disabled, all digits are shown as decimal 0–9.
- `start` while `busy`=1: ignored, not queued; `bin` changes during SHIFT have no effect.
- `bcd` holds its value between conversions and changes only on the completion edge or on reset.
- No overflow is possible for legal parameters. Maximum input 65535 yields 0x65535.

## Timing

- Reset values: state IDLE, `busy`=0, `done`=0, `bcd`=0, counter=0, shift register=0.
- Reset asserted mid-conversion:
  - aborts the conversion; no `done` pulse is produced;
  - `bcd` returns to 0 on that edge;
  - `start` is ignored on any edge where `reset`=1.
- Latency, with `start` accepted at edge N:
  - `busy` is high from after edge N through the cycle before edge N+WIDTH.
  - `bcd` updates and `done` rises after edge N+WIDTH, i.e. 16 cycles for the defaults.
  - `busy` is 0 in the `done` cycle.
- Back-to-back: `start` held high during the `done` cycle is accepted at edge N+WIDTH+1. Sustained throughput is one conversion per WIDTH+1 cycles.
- Combinational depth per cycle: DIGITS parallel nibble compare/add-3 stages plus a shift. There is no cascade across digits.

## Test plan

- Reset, then `bin`=12345, `lz_blank`=0, one-cycle `start`:
  - `busy` is high for exactly 16 cycles;
  - `done` pulses once, 16 cycles after the start edge;
  - `bcd`=0x12345.
- Boundary values:
  - `bin`=65535 gives `bcd`=0x65535.
  - `bin`=0 gives 0x00000, or 0xFFFF0 with `lz_blank`=1.
  - `bin`=9 gives 0x00009.
  - `bin`=10 gives 0x00010.
- Blanking: `bin`=42 with `lz_blank`=1 gives 0xFFF42. `bin`=1000 with `lz_blank`=1 gives 0xF1000; inner zeros are not blanked.
- Busy and back-to-back:
  - Start 300, then pulse `start` with `bin`=7 at cycle 5: ignored, result 0x00300.
  - Holding `start` with `bin`=7 through the `done` cycle starts a new conversion at the next edge; its `done` occurs 17 cycles after the first `done`, with 0x00007.
- Reset mid-operation: assert `reset` 8 cycles into converting 54321:
  - `busy`, `done` and `bcd` go to 0 on that edge;
  - no `done` ever appears for 54321;
  - a subsequent conversion of 54321 completes normally with 0x54321.
- Random regression: 1000 random `bin` and `lz_blank` values compared against a decimal reference model, with `done` occurring exactly once per accepted start.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) feeding the
// 7-segment display driver, with optional leading-zero blanking (nibble 4'hF = dark digit).
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  lz_blank,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW  = 4 * DIGITS;
    localparam int SRW = BW + WIDTH;
    localparam int CW  = $clog2(WIDTH + 1);

    // Handshake: start is accepted only on an edge where busy=0 and reset=0; bin and
    // lz_blank are captured on that same edge. busy stays high for WIDTH cycles, then
    // done pulses for one cycle with bcd already valid; bcd holds until the next done.
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [SRW-1:0]   sr_q, sr_d, sr_adj, sr_shl;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lz_q, lz_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             done_q, done_d;

    function automatic logic [BW-1:0] blank_leading(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          leading;
        r       = v;
        leading = 1'b1;
        // Digit 0 is excluded so a zero value still shows a single "0".
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (leading && (v[4*k +: 4] == 4'd0))
                r[4*k +: 4] = 4'hF;
            else
                leading = 1'b0;
        end
        return r;
    endfunction

    // Each BCD nibble is corrected independently; no carry crosses digit boundaries.
    always_comb begin
        sr_adj = sr_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr_q[WIDTH + 4*d +: 4] >= 4'd5)
                sr_adj[WIDTH + 4*d +: 4] = sr_q[WIDTH + 4*d +: 4] + 4'd3;
        end
    end

    assign sr_shl = {sr_adj[SRW-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        lz_d    = lz_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {{BW{1'b0}}, bin};
                    lz_d    = lz_blank;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_shl;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bcd_d   = lz_q ? blank_leading(sr_shl[SRW-1:WIDTH]) : sr_shl[SRW-1:WIDTH];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            lz_q    <= 1'b0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            lz_q    <= lz_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed boundary/timing cases plus a random regression
// against a decimal reference model.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic        lz_blank;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    int tests      = 0;
    int fails      = 0;
    int exp_done   = 0;
    int done_pulses = 0;
    logic [19:0] exp_q[$];

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .lz_blank (lz_blank),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // decimal reference: digit k = (v / 10^k) % 10, leading zeros above digit 0 -> F
    function automatic logic [19:0] ref_bcd(input int v, input logic lz);
        logic [19:0] r;
        int          d;
        bit          leading;
        r       = '0;
        leading = 1'b1;
        for (int k = 4; k >= 0; k--) begin
            d = (v / (10 ** k)) % 10;
            if (lz && leading && d == 0 && k > 0) r[4*k +: 4] = 4'hF;
            else begin
                r[4*k +: 4] = 4'(d);
                leading = 1'b0;
            end
        end
        return r;
    endfunction

    // driver: called at a negedge while idle; returns at the negedge after the done cycle
    task automatic run_conv(input logic [15:0] v, input logic lz, input logic [19:0] exp_v,
                            input string tag);
        int          cyc;
        int          busy_cnt;
        logic [19:0] e;
        exp_q.push_back(exp_v);
        bin      = v;
        lz_blank = lz;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        bin      = 16'($urandom);
        lz_blank = 1'($urandom);
        cyc      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, 16);
        check({tag, " busy_cycles"}, busy_cnt, 16);
        check({tag, " busy_in_done"}, busy, 0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
        check({tag, " bcd"}, bcd, e);
        exp_done++;
        @(negedge clk);
        check({tag, " done_single"}, done, 0);
        check({tag, " bcd_hold"}, bcd, e);
    endtask

    initial begin
        int          cyc;
        int          cyc2;
        int          dcount;
        logic [15:0] rv;
        logic        rl;

        reset    = 1'b1;
        start    = 1'b0;
        bin      = '0;
        lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset bcd", bcd, 0);
        reset = 1'b0;
        @(negedge clk);

        run_conv(16'd12345, 1'b0, 20'h12345, "b12345");
        run_conv(16'd65535, 1'b0, 20'h65535, "b65535");
        run_conv(16'd0,     1'b0, 20'h00000, "b0");
        run_conv(16'd0,     1'b1, 20'hFFFF0, "b0_lz");
        run_conv(16'd9,     1'b0, 20'h00009, "b9");
        run_conv(16'd10,    1'b0, 20'h00010, "b10");
        run_conv(16'd42,    1'b1, 20'hFFF42, "b42_lz");
        run_conv(16'd1000,  1'b1, 20'hF1000, "b1000_lz");

        // start while busy is ignored
        bin = 16'd300; lz_blank = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (cyc == 5) begin start = 1'b1; bin = 16'd7; end
            if (cyc == 6) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        exp_done++;
        check("ignore latency", cyc, 16);
        check("ignore bcd", bcd, 20'h00300);
        @(negedge clk);
        check("ignore idle_after", busy, 0);

        // back-to-back: start held through the done cycle
        bin = 16'd300; lz_blank = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (cyc == 15) begin start = 1'b1; bin = 16'd7; end
            @(negedge clk);
            cyc++;
        end
        exp_done++;
        check("b2b first latency", cyc, 16);
        check("b2b first bcd", bcd, 20'h00300);
        @(negedge clk);
        cyc2  = 1;
        start = 1'b0;
        bin   = 16'($urandom);
        check("b2b second busy", busy, 1);
        while (done !== 1'b1 && cyc2 < 40) begin
            @(negedge clk);
            cyc2++;
        end
        exp_done++;
        check("b2b spacing", cyc2, 17);
        check("b2b second bcd", bcd, 20'h00007);
        @(negedge clk);

        // reset mid-conversion, with start asserted during reset
        bin = 16'd54321; lz_blank = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 7) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst busy_before", busy, 1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst bcd", bcd, 0);
        reset = 1'b0;
        start = 1'b0;
        dcount = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("midrst no_done", dcount, 0);
        check("midrst bcd_still0", bcd, 0);
        run_conv(16'd54321, 1'b0, 20'h54321, "after_rst");

        // random regression
        for (int i = 0; i < 1000; i++) begin
            rv = 16'($urandom_range(0, 65535));
            rl = 1'($urandom_range(0, 1));
            run_conv(rv, rl, ref_bcd(int'(rv), rl), "rand");
        end

        check("done pulse count", done_pulses, exp_done);
        check("scoreboard empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
